// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester link: framing states, delimiter length,
// idle line level and the half-bit coding rule (1 = low then high).
package manchester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_EOF
    } tx_state_t;

    localparam int   SFD_BITS   = 2;
    localparam logic IDLE_LEVEL = 1'b0;

    function automatic logic half_level(input logic bit_val, input logic second_half);
        return second_half ? bit_val : ~bit_val;
    endfunction

endpackage

// File: rtl/manchester_bit_tx.sv
// Single Manchester bit cell: a start strobe latches one bit and plays it out as two
// half-bits of CLKS_PER_HALF_BIT cycles; o_bit_done marks the last cycle so bits chain gaplessly.
module manchester_bit_tx
    import manchester_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 4
) (
    input  logic aclk,
    input  logic areset,
    input  logic i_start,
    input  logic i_bit,
    output logic o_line,
    output logic o_bit_done
);

    localparam int HALF_W = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 1);

    logic              r_busy;
    logic              r_bit;
    logic              r_second;
    logic [HALF_W-1:0] r_half_cnt;
    logic              w_half_end;

    assign w_half_end = (r_half_cnt == HALF_LAST);
    assign o_bit_done = r_busy && r_second && w_half_end;
    assign o_line     = r_busy ? half_level(r_bit, r_second) : IDLE_LEVEL;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_busy     <= 1'b0;
            r_bit      <= 1'b0;
            r_second   <= 1'b0;
            r_half_cnt <= '0;
        end else if (i_start) begin
            r_busy     <= 1'b1;
            r_bit      <= i_bit;
            r_second   <= 1'b0;
            r_half_cnt <= '0;
        end else if (r_busy) begin
            if (w_half_end) begin
                r_half_cnt <= '0;
                r_second   <= ~r_second;
                if (r_second) begin
                    r_busy <= 1'b0;
                end
            end else begin
                r_half_cnt <= r_half_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/manchester_encoder_tx.sv
// Manchester frame transmitter: preamble, SFD, bytes MSB first, then a low EOF violation.
// IDLE: wait for byte | PREAMBLE: 1010.. | SFD: two 1s | DATA: shift bytes | EOF: line held low
module manchester_encoder_tx
    import manchester_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int PREAMBLE_BITS     = 16,
    parameter int EOF_BITS          = 2
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       serial_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       err_underrun
);

    localparam int BIT_CNT_W  = (PREAMBLE_BITS > 8) ? $clog2(PREAMBLE_BITS) : 3;
    localparam int EOF_CYCLES = EOF_BITS * 2 * CLKS_PER_HALF_BIT;
    localparam int EOF_CNT_W  = $clog2(EOF_CYCLES);
    localparam logic [BIT_CNT_W-1:0] PRE_LAST  = BIT_CNT_W'(PREAMBLE_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] SFD_LAST  = BIT_CNT_W'(SFD_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] BYTE_LAST = BIT_CNT_W'(7);
    localparam logic [EOF_CNT_W-1:0] EOF_LOAD  = EOF_CNT_W'(EOF_CYCLES - 1);

    tx_state_t            r_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [7:0]           r_shift;
    logic                 r_last;
    logic [8:0]           r_hold;
    logic                 r_hold_valid;
    logic [EOF_CNT_W-1:0] r_eof_cnt;
    logic                 r_tx_active;
    logic                 r_tx_done;
    logic                 r_err_underrun;

    logic w_accept;
    logic w_bit_done;
    logic w_bit_start;
    logic w_bit_val;
    logic w_byte_end;
    logic w_boundary;
    logic w_load;

    assign s_ready      = ~r_hold_valid && (r_state != ST_EOF) && ~areset;
    assign w_accept     = s_valid && s_ready;
    assign tx_active    = r_tx_active;
    assign tx_done      = r_tx_done;
    assign err_underrun = r_err_underrun;

    // A byte boundary follows the SFD or any non-last byte; it needs the holding reg full.
    assign w_byte_end = w_bit_done && (r_state == ST_DATA) && (r_bit_cnt == BYTE_LAST);
    assign w_boundary = (w_bit_done && (r_state == ST_SFD) && (r_bit_cnt == SFD_LAST))
                     || (w_byte_end && !r_last);
    assign w_load     = w_boundary && r_hold_valid;

    always_comb begin
        w_bit_start = 1'b0;
        w_bit_val   = 1'b1;
        if (w_load) begin
            w_bit_start = 1'b1;
            w_bit_val   = r_hold[7];
        end else begin
            unique case (r_state)
                ST_IDLE:     w_bit_start = r_hold_valid || w_accept;
                ST_PREAMBLE: begin
                    w_bit_start = w_bit_done;
                    w_bit_val   = r_bit_cnt[0];
                end
                ST_SFD:      w_bit_start = w_bit_done && (r_bit_cnt != SFD_LAST);
                ST_DATA:     begin
                    w_bit_start = w_bit_done && (r_bit_cnt != BYTE_LAST);
                    w_bit_val   = r_shift[6];
                end
                default:     w_bit_start = 1'b0;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_last         <= 1'b0;
            r_hold         <= '0;
            r_hold_valid   <= 1'b0;
            r_eof_cnt      <= '0;
            r_tx_active    <= 1'b0;
            r_tx_done      <= 1'b0;
            r_err_underrun <= 1'b0;
        end else begin
            r_tx_done      <= 1'b0;
            r_err_underrun <= 1'b0;

            if (w_accept) begin
                r_hold       <= {s_last, s_data};
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
            if (w_load) begin
                r_shift <= r_hold[7:0];
                r_last  <= r_hold[8];
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_bit_start) begin
                        r_state     <= ST_PREAMBLE;
                        r_bit_cnt   <= '0;
                        r_tx_active <= 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    if (w_bit_done) begin
                        if (r_bit_cnt == PRE_LAST) begin
                            r_state   <= ST_SFD;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_SFD, ST_DATA: begin
                    if (w_bit_done) begin
                        if (w_load) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                        end else if (w_boundary || w_byte_end) begin
                            r_state        <= ST_EOF;
                            r_eof_cnt      <= EOF_LOAD;
                            r_err_underrun <= w_boundary;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_state == ST_DATA) begin
                                r_shift <= r_shift << 1;
                            end
                        end
                    end
                end
                ST_EOF: begin
                    if (r_eof_cnt == '0) begin
                        r_state     <= ST_IDLE;
                        r_tx_active <= 1'b0;
                        r_tx_done   <= 1'b1;
                    end else begin
                        r_eof_cnt <= r_eof_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    manchester_bit_tx #(
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_bit_tx (
        .aclk      (aclk),
        .areset    (areset),
        .i_start   (w_bit_start),
        .i_bit     (w_bit_val),
        .o_line    (serial_out),
        .o_bit_done(w_bit_done)
    );

endmodule

// File: tb/tb_manchester_encoder_tx.sv
// Bench for manchester_encoder_tx: random byte streams, each captured frame compared
// against a waveform rebuilt from the framing rules and the bytes handed to the DUT.
module tb_manchester_encoder_tx;

    localparam int H = 4;
    localparam int P = 16;
    localparam int E = 2;

    logic       aclk    = 1'b0;
    logic       areset  = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;
    logic       s_ready;
    logic       serial_out;
    logic       tx_active;
    logic       tx_done;
    logic       err_underrun;

    manchester_encoder_tx #(
        .CLKS_PER_HALF_BIT(H),
        .PREAMBLE_BITS    (P),
        .EOF_BITS         (E)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .serial_out  (serial_out),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .err_underrun(err_underrun)
    );

    always #5 aclk = ~aclk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_done   = 0;
    int           n_err    = 0;
    bit           abort    = 1'b0;
    logic [7:0]   exp_bytes[$];
    int           exp_len[$];
    logic         wave[$];
    logic [127:0] last_dec;
    int           last_cycles;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference line for one frame: bits from the framing rules, each bit as !b then b.
    task automatic check_frame();
        logic       bits[$];
        logic       exp_w[$];
        logic [7:0] b;
        int         n;
        int         errs;
        int         idx;
        if (exp_len.size() == 0) begin
            check_val("unexpected_frame", 64'(wave.size()), 64'd0);
            return;
        end
        n = exp_len.pop_front();
        for (int i = 0; i < P; i++) bits.push_back((i % 2) == 0);
        bits.push_back(1'b1);
        bits.push_back(1'b1);
        for (int k = 0; k < n; k++) begin
            b = exp_bytes.pop_front();
            for (int j = 7; j >= 0; j--) bits.push_back(b[j]);
        end
        foreach (bits[i]) begin
            repeat (H) exp_w.push_back(!bits[i]);
            repeat (H) exp_w.push_back(bits[i]);
        end
        repeat (2 * H * E) exp_w.push_back(1'b0);
        errs = 0;
        for (int i = 0; i < wave.size() && i < exp_w.size(); i++)
            if (wave[i] !== exp_w[i]) errs++;
        check_val("frame_len", 64'(wave.size()), 64'(exp_w.size()));
        check_val("frame_wave", 64'(errs), 64'd0);
        check_val("tx_done_on_fall", 64'(tx_done), 64'd1);
        last_cycles = wave.size();
        last_dec = '0;
        for (int k = 0; k < n && k < 16; k++) begin
            for (int j = 0; j < 8; j++) begin
                idx = (P + 2 + 8 * k + j) * 2 * H + H;
                last_dec = {last_dec[126:0], (idx < wave.size()) ? wave[idx] : 1'bx};
            end
        end
    endtask

    always @(negedge aclk) begin
        if (tx_done) n_done++;
        if (err_underrun) n_err++;
        if (areset || abort) wave.delete();
        else if (tx_active) wave.push_back(serial_out);
        else if (wave.size() != 0) begin
            check_frame();
            wave.delete();
        end
    end

    // Data and last are scrambled whenever the DUT is not ready; only the handshaked value is real.
    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int waited;
        repeat (gap) begin
            @(negedge aclk);
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
        end
        waited = 0;
        forever begin
            @(negedge aclk);
            s_valid = 1'b1;
            if (s_ready) begin
                s_data = b;
                s_last = last;
                @(posedge aclk);
                break;
            end
            s_data = 8'($urandom);
            s_last = 1'($urandom);
            waited++;
            if (waited > 3000) begin
                check_val("hs_timeout_ready", 64'(s_ready), 64'd1);
                break;
            end
        end
    endtask

    task automatic idle_in();
        @(negedge aclk);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic send_frame(input int n, input int first_gap, input int max_gap);
        logic [7:0] b;
        exp_len.push_back(n);
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            exp_bytes.push_back(b);
            send_byte(b, k == n - 1, (k == 0) ? first_gap : $urandom_range(max_gap, 0));
        end
    endtask

    task automatic wait_quiet(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge aclk);
            if (exp_len.size() == 0 && !tx_active) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("frame_timeout", 64'(exp_len.size()) + 64'(tx_active), 64'd0);
    endtask

    initial begin
        logic [7:0] f1[6];
        int         d0;
        int         e0;
        bit         seen;

        f1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        #1 areset = 1'b1;
        repeat (3) @(negedge aclk);
        check_val("rst_serial_out", 64'(serial_out), 64'd0);
        check_val("rst_s_ready", 64'(s_ready), 64'd0);
        check_val("rst_tx_active", 64'(tx_active), 64'd0);
        check_val("rst_tx_done", 64'(tx_done), 64'd0);
        check_val("rst_err_underrun", 64'(err_underrun), 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        check_val("ready_after_reset", 64'(s_ready), 64'd1);

        // Six-byte frame with s_valid held
        d0 = n_done;
        exp_len.push_back(6);
        foreach (f1[k]) exp_bytes.push_back(f1[k]);
        foreach (f1[k]) send_byte(f1[k], k == 5, 0);
        idle_in();
        wait_quiet(3000);
        check_val("dec_aabbccddeeff", 64'(last_dec[47:0]), 64'h0000_AABB_CCDD_EEFF);
        check_val("active_cycles_6", 64'(last_cycles), 64'd544);
        check_val("done_count_6", 64'(n_done - d0), 64'd1);

        // Single byte 0x80
        d0 = n_done;
        exp_len.push_back(1);
        exp_bytes.push_back(8'h80);
        send_byte(8'h80, 1'b1, 2);
        idle_in();
        wait_quiet(2000);
        check_val("dec_80", 64'(last_dec[7:0]), 64'h80);
        check_val("active_cycles_1", 64'(last_cycles), 64'd224);
        check_val("done_count_1", 64'(n_done - d0), 64'd1);

        // Underrun: second byte arrives only after the first frame has been cut
        e0 = n_err;
        d0 = n_done;
        exp_len.push_back(1);
        exp_bytes.push_back(8'h5A);
        exp_len.push_back(1);
        exp_bytes.push_back(8'hC3);
        send_byte(8'h5A, 1'b0, 0);
        idle_in();
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            if (n_err > e0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val("underrun_timeout", 64'(n_err - e0), 64'd1);
        send_byte(8'hC3, 1'b1, 0);
        idle_in();
        wait_quiet(2000);
        check_val("underrun_count", 64'(n_err - e0), 64'd1);
        check_val("underrun_frames", 64'(n_done - d0), 64'd2);

        // Random frames, gaps shorter than a byte time
        e0 = n_err;
        d0 = n_done;
        for (int f = 0; f < 40; f++) send_frame($urandom_range(16, 1), $urandom_range(20, 0), 40);
        idle_in();
        wait_quiet(4000);
        check_val("rand_done", 64'(n_done - d0), 64'd40);
        check_val("rand_underrun", 64'(n_err - e0), 64'd0);

        // Reset in the middle of a data byte
        e0 = n_err;
        d0 = n_done;
        send_byte(8'h3C, 1'b0, 0);
        send_byte(8'h96, 1'b1, 0);
        idle_in();
        repeat (20) @(posedge aclk);
        #2;
        abort  = 1'b1;
        areset = 1'b1;
        #1;
        check_val("abort_serial_out", 64'(serial_out), 64'd0);
        check_val("abort_s_ready", 64'(s_ready), 64'd0);
        @(negedge aclk);
        check_val("abort_tx_active", 64'(tx_active), 64'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        abort = 1'b0;
        check_val("abort_no_done", 64'(n_done - d0), 64'd0);
        check_val("abort_no_underrun", 64'(n_err - e0), 64'd0);
        send_frame(3, 1, 3);
        idle_in();
        wait_quiet(2000);
        check_val("post_abort_done", 64'(n_done - d0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
